// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding and default bit period, also used by the receiver.
// No logic; no latency or flow control of its own.
package uart_pkg;

  localparam int CLK_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick is high on the last cycle of each bit, zero latency from count.
// No backpressure; clear holds the count at zero so the next bit starts aligned.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an 8N1 UART line; 3 cycles from non-empty to start bit, 10 bit-times per frame.
// No backpressure input: pops one byte only when the previous frame's stop bit is done.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_q, tx_d;
  logic        baud_clear;
  logic        baud_tick;

  // Counter is held at zero until the first START cycle so every bit is exactly one period.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

  uart_baud_cnt #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = fifo_data;
        tx_d      = 1'b0;
        bit_cnt_d = 3'd0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign fifo_pop = (state_q == ST_POP);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at 4 clocks per bit: behavioural FIFO, frame-position reference model,
// serial-line decoder, directed cases and a randomized 1024-byte stream.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstn;
  logic       fifo_empty = 1'b1;
  logic       fifo_pop;
  logic [7:0] fifo_data = 8'd0;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  logic [7:0] pend_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  int         frame_starts[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte FIFO with registered read data; pushes land at the next rising edge.
  logic [7:0] pop_tmp;
  always @(posedge clk) begin
    if (fifo_pop && q.size() > 0) begin
      pop_tmp = q.pop_front();
      fifo_data <= pop_tmp;
    end
    while (pend_q.size() > 0) q.push_back(pend_q.pop_front());
    fifo_empty <= (q.size() == 0);
  end

  // Reference: k = cycles since the pop strobe (-1 when idle); the frame starts at k=2.
  int         k  = -1;
  logic [7:0] mb = 8'd0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k = -1;
    end else if (k < 0) begin
      if (!fifo_empty) begin
        k  = 0;
        mb = q[0];
      end
    end else if (k == FRAME + 1) begin
      k = -1;
    end else begin
      k++;
    end
  end

  function automatic logic model_tx(input int kk, input logic [7:0] b);
    int idx;
    if (kk < 2) return 1'b1;
    idx = (kk - 2) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  logic prev_pop = 1'b0;
  always @(negedge clk) begin
    chk("outputs{pop,busy,tx}", 64'({fifo_pop, busy, tx}),
        64'({(k == 0), (k >= 0), model_tx(k, mb)}));
    chk("pop_while_empty", 64'(fifo_pop & fifo_empty), 64'd0);
    chk("pop_two_cycles", 64'(prev_pop & fifo_pop), 64'd0);
    prev_pop = fifo_pop;
  end

  // Serial-line decoder: samples each bit mid-period from the falling edge of the start bit.
  logic        m_act = 1'b0;
  int          m_cnt = 0;
  int          m_start = 0;
  logic [39:0] m_bits = '0;
  logic [39:0] last_frame = '0;
  logic [7:0]  m_byte;
  always @(negedge clk) begin
    if (!rstn) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx == 1'b0) begin
        m_act   = 1'b1;
        m_cnt   = 0;
        m_start = cyc;
        m_bits  = '0;
      end
    end else begin
      m_cnt++;
      m_bits[m_cnt] = tx;
      if (m_cnt == FRAME - 1) begin
        for (int i = 0; i < 8; i++) m_byte[i] = m_bits[CPB*(i+1) + CPB/2];
        chk("start_bit_low", 64'(m_bits[CPB-1:0]), 64'd0);
        chk("stop_bit_high", 64'(m_bits[FRAME-CPB/2]), 64'd1);
        rx_q.push_back(m_byte);
        frame_starts.push_back(m_start);
        last_frame = m_bits;
        m_act = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    pend_q.push_back(b);
    sent_q.push_back(b);
  endtask

  function automatic logic is_idle();
    return (k < 0) && fifo_empty && (pend_q.size() == 0) && !m_act;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!is_idle() && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  initial begin
    #1_500_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, pop_cnt, busy_cnt, low_cnt, bad, gap;
    logic [9:0]  pat;
    logic [39:0] exp40;

    rstn = 1'b0;
    tick(5);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pop", 64'(fifo_pop), 64'd0);
    rstn = 1'b1;
    tick(3);

    // Empty FIFO for 100 cycles: nothing moves.
    pop_cnt = 0; busy_cnt = 0; low_cnt = 0;
    repeat (100) begin
      tick(1);
      if (fifo_pop) pop_cnt++;
      if (busy) busy_cnt++;
      if (!tx) low_cnt++;
    end
    chk("idle_pops", 64'(pop_cnt), 64'd0);
    chk("idle_busy", 64'(busy_cnt), 64'd0);
    chk("idle_tx_low", 64'(low_cnt), 64'd0);

    // Single 0x55: busy covers POP and LOAD plus the 40-cycle frame.
    rx_q.delete();
    push(8'h55);
    pop_cnt = 0; busy_cnt = 0; n = 0;
    while (!is_idle() && n < 200) begin
      tick(1);
      n++;
      if (fifo_pop) pop_cnt++;
      if (busy) busy_cnt++;
    end
    chk("x55_timeout", 64'(n >= 200), 64'd0);
    chk("x55_pop_count", 64'(pop_cnt), 64'd1);
    chk("x55_busy_cycles", 64'(busy_cnt), 64'd42);
    chk("x55_frames", 64'(rx_q.size()), 64'd1);
    chk("x55_byte", 64'(rx_q[0]), 64'h55);
    pat = 10'b1010101010;
    for (int j = 0; j < FRAME; j++) exp40[j] = pat[j/CPB];
    chk("x55_waveform", 64'(last_frame), 64'(exp40));

    // Back-to-back 0xA5, 0x3C: next start is 40+3 cycles after the first.
    rx_q.delete();
    frame_starts.delete();
    push(8'hA5);
    push(8'h3C);
    wait_idle(400, "b2b");
    chk("b2b_frames", 64'(rx_q.size()), 64'd2);
    chk("b2b_byte0", 64'(rx_q[0]), 64'hA5);
    chk("b2b_byte1", 64'(rx_q[1]), 64'h3C);
    chk("b2b_start_spacing", 64'(frame_starts[1] - frame_starts[0]), 64'd43);

    // Reset during data bit 3 of 0xFF; queued 0x0F must follow intact.
    rx_q.delete();
    push(8'hFF);
    push(8'h0F);
    n = 0;
    while (!(m_act && m_cnt == 4*CPB + 1) && n < 200) begin
      tick(1);
      n++;
    end
    chk("rst_reach_bit3_timeout", 64'(n >= 200), 64'd0);
    rstn = 1'b0;
    #1;
    chk("rst_async_tx", 64'(tx), 64'd1);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_pop", 64'(fifo_pop), 64'd0);
    tick(3);
    rstn = 1'b1;
    wait_idle(400, "rst_recover");
    chk("rst_frames", 64'(rx_q.size()), 64'd1);
    chk("rst_next_byte", 64'(rx_q[0]), 64'h0F);

    // Randomized stream with mixed short and long gaps.
    rx_q.delete();
    sent_q.delete();
    for (int i = 0; i < 1024; i++) begin
      push(8'($urandom_range(0, 255)));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120)) : int'($urandom_range(0, 20));
      tick(gap);
    end
    wait_idle(60000, "random");
    chk("random_count", 64'(rx_q.size()), 64'd1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== sent_q[i]) bad++;
    end
    chk("random_bytes_mismatched", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
